// File: rtl/dab_adc_acquire.sv
// dab_adc_acquire: triggered capture of three serial ADCs, offset binary to signed output.
// Define DAB_ADC_AVG_EN to output a 4-sample moving average per channel.
module dab_adc_acquire #(
  parameter int NBITS      = 14,
  parameter int LEAD_ZEROS = 2,
  parameter int CLK_DIV    = 2,
  parameter int T_QUIET    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    trigger,
  input  logic [2:0]              adc_sdata,
  output logic                    adc_cs_n,
  output logic                    adc_sclk,
  output logic signed [NBITS-1:0] Vdc1,
  output logic signed [NBITS-1:0] Vdc2,
  output logic signed [NBITS-1:0] Iref,
  output logic                    valid,
  output logic                    busy,
  output logic                    overrun
);
  localparam int F  = LEAD_ZEROS + NBITS;
  localparam int PW = $clog2(2 * CLK_DIV);
  localparam int BW = $clog2(F + 1);
  localparam int QW = $clog2(T_QUIET + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE, QUIET} state_t;
  state_t        state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [QW-1:0] qcnt_q, qcnt_d;
  logic          trig_q, cs_n_q, cs_n_d, sclk_q, sclk_d, busy_q, busy_d, valid_q, ovr_q;
  logic          start, samp, upd;
  assign start    = trigger & ~trig_q;
  assign samp     = (state_q == SHIFT) && (phase_q == PW'(CLK_DIV - 1));
  assign upd      = state_q == DONE;
  assign adc_cs_n = cs_n_q;
  assign adc_sclk = sclk_q;
  assign busy     = busy_q;
  assign valid    = valid_q;
  assign overrun  = ovr_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      phase_q <= '0;
      bit_q   <= '0;
      qcnt_q  <= '0;
      trig_q  <= 1'b1;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b1;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
      qcnt_q  <= qcnt_d;
      trig_q  <= trigger;
      cs_n_q  <= cs_n_d;
      sclk_q  <= sclk_d;
      busy_q  <= busy_d;
      valid_q <= upd;
      ovr_q   <= ovr_q | (start & busy_q);
    end
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    qcnt_d  = qcnt_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = SHIFT;
        phase_d = '0;
        bit_d   = '0;
      end
      SHIFT: begin
        phase_d = (phase_q == PW'(2 * CLK_DIV - 1)) ? '0 : phase_q + PW'(1);
        if (phase_q == PW'(2 * CLK_DIV - 1)) begin
          bit_d = bit_q + BW'(1);
          if (bit_q == BW'(F - 1)) state_d = DONE;
        end
      end
      DONE: begin
        state_d = (T_QUIET > 1) ? QUIET : IDLE;
        qcnt_d  = '0;
      end
      default: begin
        qcnt_d = qcnt_q + QW'(1);
        if (int'(qcnt_q) >= T_QUIET - 2) state_d = IDLE;
      end
    endcase
  end
  // Control outputs are registered from the next state so the ADC pins never glitch.
  always_comb begin
    cs_n_d = state_d != SHIFT;
    sclk_d = !(state_d == SHIFT && phase_d < PW'(CLK_DIV));
    busy_d = state_d != IDLE;
  end
  for (genvar c = 0; c < 3; c++) begin : g_ch
    logic [NBITS-1:0]        sr_q;
    logic signed [NBITS-1:0] raw, out_q;
    assign raw = {~sr_q[NBITS-1], sr_q[NBITS-2:0]};
`ifdef DAB_ADC_AVG_EN
    localparam int SW = NBITS + 2;
    logic signed [NBITS-1:0] hist_q [3];
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        sr_q      <= '0;
        out_q     <= '0;
        hist_q[0] <= '0;
        hist_q[1] <= '0;
        hist_q[2] <= '0;
      end else begin
        if (samp) sr_q <= {sr_q[NBITS-2:0], adc_sdata[c]};
        if (upd) begin
          hist_q[0] <= raw;
          hist_q[1] <= hist_q[0];
          hist_q[2] <= hist_q[1];
          out_q     <= NBITS'((SW'(raw) + SW'(hist_q[0]) + SW'(hist_q[1]) + SW'(hist_q[2])) >>> 2);
        end
      end
`else
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        sr_q  <= '0;
        out_q <= '0;
      end else begin
        if (samp) sr_q <= {sr_q[NBITS-2:0], adc_sdata[c]};
        if (upd) out_q <= raw;
      end
`endif
  end
  assign Vdc1 = g_ch[0].out_q;
  assign Vdc2 = g_ch[1].out_q;
  assign Iref = g_ch[2].out_q;
endmodule
